vx_wb_scoreboard: RTL
=====================

// Module: vx_wb_scoreboard
// PURPOSE
//  Consumer end of the writeback interface. Retires writebacks per warp/register:
//  clears in-use bits on the final (eop) packet and releases issue when no hazard remains.
//  Sits between the instruction buffer and dispatch; holds one in-use bit per (warp, reg).
//  Also keeps per-warp outstanding-write counters and a stall watchdog.
// PARAMETERS
//  NUM_WARPS      4     warps tracked; NW_BITS = $clog2(NUM_WARPS)
//  NUM_REGS       32    architectural regs per warp (64 with EXT_F); NR_BITS = $clog2(NUM_REGS)
//  CNT_W          4     width of per-warp outstanding-write counter
//  STALL_TIMEOUT  1023  consecutive blocked-issue cycles before deadlock flag sets
// PORTS
//  clk            in   1          clock
//  reset          in   1          asynchronous, active-high reset
//  ibuf_valid     in   1          instruction offered for issue
//  ibuf_wid       in   NW_BITS    issuing warp
//  ibuf_wb        in   1          instruction writes rd
//  ibuf_rd        in   NR_BITS    destination reg
//  ibuf_rs1/2/3   in   NR_BITS    source regs (rs3 for FMA; tie to 0 if unused)
//  ibuf_ready     out  1          issue accepted (hazard-free)
//  wb_valid       in   1          writeback packet valid
//  wb_wid         in   NW_BITS    writeback warp
//  wb_rd          in   NR_BITS    writeback reg
//  wb_eop         in   1          last packet of this instruction's writeback
//  wb_ready       out  1          always 1 (scoreboard never back-pressures writeback)
//  warp_idle      out  NUM_WARPS  per warp: outstanding counter == 0
//  sb_error       out  1          sticky: eop clear of a non-busy reg, or counter over/underflow
//  sb_deadlock    out  1          sticky: STALL_TIMEOUT reached
// BEHAVIOUR
//  Reset: all in-use bits 0, counters 0, watchdog 0; ibuf_ready=1 combinationally
//   while reset asserted is don't-care (no fire accepted); warp_idle all 1; sb_error=0;
//   sb_deadlock=0; wb_ready=1. Reset mid-operation discards all state immediately.
//  Issue fire = ibuf_valid && ibuf_ready. Writeback fire = wb_valid (ready always 1).
//  release(w,r) = wb_valid && wb_eop && wb_wid==w && wb_rd==r (same-cycle bypass).
//  busy_eff(w,r) = inuse[w][r] && !release(w,r).
//  ibuf_ready = !busy_eff(wid,rs1) && !busy_eff(wid,rs2) && !busy_eff(wid,rs3)
//               && !(ibuf_wb && busy_eff(wid,rd)) && !(ibuf_wb && counter==max); comb.
//  Reg 0 never marked busy; rd==0 issue with ibuf_wb does not set a bit or count.
//  Next state (1-cycle latency to inuse): clear on release, then set on issue fire with
//   ibuf_wb && rd!=0; set wins if both hit the same (w,r).
//  Counter[w]: +1 on issue fire with wb && rd!=0; -1 on release; both same warp -> unchanged.
//   Decrement at 0 or increment at 2^CNT_W-1 -> sb_error set, counter saturates.
//  Release of a reg whose inuse bit is 0 -> sb_error set; no other state change.
//  Non-eop writeback packets change no state.
//  Watchdog: counts cycles with ibuf_valid && !ibuf_ready; clears on any other cycle;
//   on reaching STALL_TIMEOUT sets sb_deadlock (sticky until reset), counter holds.
//  sb_error/sb_deadlock registered; visible cycle after the cause.
// STRUCTURE
//  Shared package: NW_BITS/NR_BITS derivation, sb_entry_t {wid, rd} typedef.
//  Sub-module: vx_sb_warp_bank (inuse vector + counter for one warp), generated
//   NUM_WARPS times; top holds hazard muxing, watchdog, and error flags.
// TESTING
//  Issue w1 rd=5 wb -> next cycle issue w1 rs1=5 ready=0; eop wb w1 rd5 -> ready=1 same cycle.
//  Issue w0 rd=0 wb -> no bit set, counter stays 0, warp_idle[0]=1.
//  Same cycle: eop release w2 r7 and issue w2 rd=7 -> inuse[2][7]=1, counter[2] unchanged.
//  Non-eop wb w3 r4 while busy -> r4 still busy; eop wb -> cleared, warp_idle[3]=1.
//  Eop wb w0 r9 never issued -> sb_error=1 next cycle, remains 1 until reset.
//  Hold ibuf blocked 1023 cycles -> sb_deadlock=1; async reset mid-run -> all bits clear.

Source files
------------

// File: rtl/vx_wb_scoreboard_pkg.sv
// Shared types for the writeback scoreboard.
// Warp/register geometry and the (warp, reg) entry bundle.
package vx_wb_scoreboard_pkg;

  localparam int NUM_WARPS = 4;
  localparam int NUM_REGS  = 32;
  localparam int NW_BITS   = $clog2(NUM_WARPS);
  localparam int NR_BITS   = $clog2(NUM_REGS);

  typedef struct packed {
    logic [NW_BITS-1:0] wid;
    logic [NR_BITS-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/vx_wb_scoreboard_warp_bank.sv
// One warp's in-use vector and outstanding-write counter.
// Ports: set (issue), clr (eop release) -> inuse, cnt, err pulse.
module vx_sb_warp_bank
  import vx_wb_scoreboard_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set_en,
  input  logic [NR_BITS-1:0] set_rd,
  input  logic               clr_en,
  input  logic [NR_BITS-1:0] clr_rd,
  output logic [NUM_REGS-1:0] inuse,
  output logic [CNT_W-1:0]   cnt,
  output logic               err
);

  logic                hit;
  logic                inc;
  logic [NUM_REGS-1:0] inuse_n;
  logic [CNT_W-1:0]    cnt_n;

  always_comb begin
    hit     = clr_en && inuse[clr_rd];
    inc     = set_en && (set_rd != '0);
    err     = clr_en && !hit;
    inuse_n = inuse;
    cnt_n   = cnt;
    // clear first so a same-cycle set wins
    if (hit) inuse_n[clr_rd] = 1'b0;
    if (inc) inuse_n[set_rd] = 1'b1;
    unique case ({inc, hit})
      2'b10: begin
        if (cnt == '1) err = 1'b1;
        else cnt_n = cnt + CNT_W'(1);
      end
      2'b01: begin
        if (cnt == '0) err = 1'b1;
        else cnt_n = cnt - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inuse <= '0;
      cnt   <= '0;
    end else begin
      inuse <= inuse_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: rtl/vx_wb_scoreboard.sv
// Writeback scoreboard: per-(warp,reg) hazards, counters, watchdog.
// Ports: ibuf issue (valid/ready), wb retire, idle/error/deadlock.
module vx_wb_scoreboard
  import vx_wb_scoreboard_pkg::*;
#(
  parameter int CNT_W         = 4,
  parameter int STALL_TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ibuf_valid,
  input  logic [NW_BITS-1:0]   ibuf_wid,
  input  logic                 ibuf_wb,
  input  logic [NR_BITS-1:0]   ibuf_rd,
  input  logic [NR_BITS-1:0]   ibuf_rs1,
  input  logic [NR_BITS-1:0]   ibuf_rs2,
  input  logic [NR_BITS-1:0]   ibuf_rs3,
  output logic                 ibuf_ready,
  input  logic                 wb_valid,
  input  logic [NW_BITS-1:0]   wb_wid,
  input  logic [NR_BITS-1:0]   wb_rd,
  input  logic                 wb_eop,
  output logic                 wb_ready,
  output logic [NUM_WARPS-1:0] warp_idle,
  output logic                 sb_error,
  output logic                 sb_deadlock
);

  localparam int WD_W = $clog2(STALL_TIMEOUT + 1);

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] inuse;
  logic [NUM_WARPS-1:0][CNT_W-1:0]    cnt;
  logic [NUM_WARPS-1:0]               bank_err;
  logic [WD_W-1:0]                    wd;

  sb_entry_t     iss;
  sb_entry_t     rel_e;
  logic          rel;
  logic          rel_here;
  logic          iss_fire;
  logic          stall;
  logic [NUM_REGS-1:0] row;

  assign iss   = '{wid: ibuf_wid, rd: ibuf_rd};
  assign rel_e = '{wid: wb_wid, rd: wb_rd};
  assign rel   = wb_valid && wb_eop;

  assign wb_ready = 1'b1;

  // busy unless released by an eop writeback this same cycle
  function automatic logic busy_eff(
    input logic [NUM_REGS-1:0] r_row,
    input logic [NR_BITS-1:0]  r,
    input logic                r_rel,
    input logic [NR_BITS-1:0]  r_rd
  );
    return r_row[r] && !(r_rel && (r_rd == r));
  endfunction

  always_comb begin
    row      = inuse[iss.wid];
    rel_here = rel && (rel_e.wid == iss.wid);
    ibuf_ready =
      !busy_eff(row, ibuf_rs1, rel_here, rel_e.rd) &&
      !busy_eff(row, ibuf_rs2, rel_here, rel_e.rd) &&
      !busy_eff(row, ibuf_rs3, rel_here, rel_e.rd) &&
      !(ibuf_wb && busy_eff(row, iss.rd, rel_here, rel_e.rd)) &&
      !(ibuf_wb && (cnt[iss.wid] == '1));
  end

  assign iss_fire = ibuf_valid && ibuf_ready;
  assign stall    = ibuf_valid && !ibuf_ready;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_bank
    vx_sb_warp_bank #(
      .CNT_W (CNT_W)
    ) u_bank (
      .clk    (clk),
      .reset  (reset),
      .set_en (iss_fire && ibuf_wb && (iss.wid == NW_BITS'(w))),
      .set_rd (iss.rd),
      .clr_en (rel && (rel_e.wid == NW_BITS'(w))),
      .clr_rd (rel_e.rd),
      .inuse  (inuse[w]),
      .cnt    (cnt[w]),
      .err    (bank_err[w])
    );
    assign warp_idle[w] = (cnt[w] == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_error    <= 1'b0;
      sb_deadlock <= 1'b0;
      wd          <= '0;
    end else begin
      if (|bank_err) sb_error <= 1'b1;
      if (stall) begin
        // saturate at the timeout; flag latches on arrival
        if (wd != WD_W'(STALL_TIMEOUT)) begin
          wd <= wd + WD_W'(1);
          if (wd == WD_W'(STALL_TIMEOUT - 1))
            sb_deadlock <= 1'b1;
        end
      end else begin
        wd <= '0;
      end
    end
  end

endmodule
